stream_to_bram: RTL and testbench

STREAM_TO_BRAM -- requirements
Module: stream_to_bram

---
 rtl/stream_to_bram.sv | 133 +++++++++++++
 tb/tb_stream_to_bram.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_to_bram.sv
// rtl/stream_to_bram.sv - AXI-stream sink that captures words into a BRAM port
// Supports immediate, orbit-synchronous and ring-buffer capture modes.
module stream_to_bram #(
  parameter int MEM_DEPTH = 2048
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic [31:0] data_stream_TDATA,
  input  logic        data_stream_TVALID,
  output logic        data_stream_TREADY,
  input  logic        fc_orbitSync,
  input  logic        cfg_arm,
  input  logic        cfg_abort,
  input  logic [1:0]  cfg_mode,
  input  logic [15:0] cfg_length,
  output logic        bram_CLK,
  output logic        bram_RST,
  output logic        bram_EN,
  output logic [3:0]  bram_WE,
  output logic [31:0] bram_ADDR,
  output logic [31:0] bram_DIN,
  output logic        status_busy,
  output logic        status_done,
  output logic        status_wrapped,
  output logic [15:0] status_count
);

  localparam logic [16:0] DEPTH_W  = 17'(MEM_DEPTH);
  localparam logic [15:0] DEPTH_M1 = 16'(MEM_DEPTH - 1);
  localparam logic [1:0]  MODE_SYNC = 2'd1;
  localparam logic [1:0]  MODE_RING = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SYNC, S_CAPTURE, S_DONE} state_t;
  state_t state, state_next;

  logic        tready_q;
  logic        sync_prev;
  logic [1:0]  mode_q;
  logic [15:0] len_m1_q;
  logic [15:0] ptr;
  logic [15:0] count;
  logic        wrapped;

  logic        orbit_edge;
  logic        do_write;
  logic        last_word;
  logic        arm_take;
  logic [1:0]  mode_new;
  logic [15:0] len_m1_new;

  assign bram_CLK           = clk;
  assign bram_RST           = ~aresetn;
  assign bram_EN            = 1'b1;
  assign data_stream_TREADY = tready_q;
  assign status_busy        = (state == S_WAIT_SYNC) || (state == S_CAPTURE);
  assign status_done        = (state == S_DONE);
  assign status_wrapped     = wrapped;
  assign status_count       = count;

  // Length is kept as L-1 so that L = 65536 still fits in 16 bits.
  assign len_m1_new = ((cfg_length == 16'd0) || ({1'b0, cfg_length} > DEPTH_W))
                      ? DEPTH_M1 : (cfg_length - 16'd1);
  assign mode_new   = (cfg_mode == 2'd3) ? 2'd0 : cfg_mode;

  assign orbit_edge = fc_orbitSync & ~sync_prev;
  assign do_write   = data_stream_TVALID & tready_q &
                      ((state == S_CAPTURE) || ((state == S_WAIT_SYNC) && orbit_edge));
  assign last_word  = (ptr == len_m1_q);
  assign arm_take   = cfg_arm & ~cfg_abort & ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (arm_take) state_next = (mode_new == MODE_SYNC) ? S_WAIT_SYNC : S_CAPTURE;
      end
      S_WAIT_SYNC: begin
        if (cfg_abort)       state_next = S_IDLE;
        else if (orbit_edge) state_next = (do_write && last_word) ? S_DONE : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (cfg_abort)
          state_next = (mode_q == MODE_RING) ? S_DONE : S_IDLE;
        else if (do_write && last_word && (mode_q != MODE_RING))
          state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Arm and write are exclusive: arm is only taken in IDLE/DONE, writes only while busy.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      tready_q  <= 1'b0;
      sync_prev <= 1'b0;
      mode_q    <= 2'd0;
      len_m1_q  <= 16'd0;
      ptr       <= 16'd0;
      count     <= 16'd0;
      wrapped   <= 1'b0;
      bram_WE   <= 4'h0;
      bram_ADDR <= 32'd0;
      bram_DIN  <= 32'd0;
    end else begin
      tready_q  <= 1'b1;
      sync_prev <= fc_orbitSync;
      bram_WE   <= do_write ? 4'hF : 4'h0;
      if (arm_take) begin
        mode_q   <= mode_new;
        len_m1_q <= len_m1_new;
        ptr      <= 16'd0;
        count    <= 16'd0;
        wrapped  <= 1'b0;
      end else if (do_write) begin
        bram_ADDR <= {14'd0, ptr, 2'b00};
        bram_DIN  <= data_stream_TDATA;
        if ((mode_q == MODE_RING) && last_word) begin
          ptr     <= 16'd0;
          wrapped <= 1'b1;
        end else begin
          ptr <= ptr + 16'd1;
        end
        if (count != 16'hFFFF) count <= count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_stream_to_bram.sv
// tb/tb_stream_to_bram.sv - directed testbench for stream_to_bram
// Inputs change and outputs are sampled on the falling clock edge.
module tb_stream_to_bram;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        orbit;
  logic        cfg_arm, cfg_abort;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_length;
  logic        bram_CLK, bram_RST, bram_EN;
  logic [3:0]  bram_WE;
  logic [31:0] bram_ADDR, bram_DIN;
  logic        busy, done, wrapped;
  logic [15:0] count;

  int checks = 0;
  int errors = 0;
  int reset_writes = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] mem [0:2047];

  always #5 clk = ~clk;

  stream_to_bram dut (
    .clk(clk), .aresetn(aresetn),
    .data_stream_TDATA(tdata), .data_stream_TVALID(tvalid), .data_stream_TREADY(tready),
    .fc_orbitSync(orbit), .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
    .cfg_mode(cfg_mode), .cfg_length(cfg_length),
    .bram_CLK(bram_CLK), .bram_RST(bram_RST), .bram_EN(bram_EN), .bram_WE(bram_WE),
    .bram_ADDR(bram_ADDR), .bram_DIN(bram_DIN),
    .status_busy(busy), .status_done(done), .status_wrapped(wrapped), .status_count(count)
  );

  // BRAM model: records every write the DUT presents.
  always @(negedge clk) begin
    if (!aresetn && bram_WE !== 4'h0) reset_writes++;
    if (bram_WE === 4'hF) begin
      wr_addr_q.push_back(bram_ADDR);
      wr_data_q.push_back(bram_DIN);
      mem[bram_ADDR[12:2]] = bram_DIN;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic arm(input logic [1:0] m, input logic [15:0] len);
    cfg_mode = m; cfg_length = len; cfg_arm = 1'b1;
    cyc(1);
    cfg_arm = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d);
    tdata = d; tvalid = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset;
    aresetn = 1'b0; tdata = 32'd0; tvalid = 1'b0; orbit = 1'b0;
    cfg_arm = 1'b0; cfg_abort = 1'b0; cfg_mode = 2'd0; cfg_length = 16'd0;
    cyc(2);
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b expected 0", tready); end
    checks++; if (bram_WE !== 4'h0) begin errors++; $display("FAIL rst_we: got %h expected 0", bram_WE); end
    checks++; if ({busy, done, wrapped} !== 3'b000) begin errors++; $display("FAIL rst_status: got %b expected 000", {busy, done, wrapped}); end
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
    checks++; if ({bram_ADDR, bram_DIN} !== 64'd0) begin errors++; $display("FAIL rst_addr_din: got %h/%h expected 0/0", bram_ADDR, bram_DIN); end
    checks++; if ({bram_RST, bram_EN} !== 2'b11) begin errors++; $display("FAIL rst_bram_ctl: got %b expected 11", {bram_RST, bram_EN}); end
    aresetn = 1'b1;
    cyc(1);
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL post_rst_tready: got %b expected 1", tready); end
    checks++; if ({bram_RST, bram_EN} !== 2'b01) begin errors++; $display("FAIL post_rst_bram_ctl: got %b expected 01", {bram_RST, bram_EN}); end
  endtask

  task automatic test_immediate;
    logic [31:0] exp_a [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    wr_addr_q.delete(); wr_data_q.delete();
    arm(2'd0, 16'd4);
    cfg_mode = 2'd2; cfg_length = 16'd1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL m0_busy: got %b expected 1", busy); end
    for (int i = 0; i < 6; i++) beat(32'hA0 + 32'(i));
    tvalid = 1'b0;
    cyc(3);
    checks++; if (wr_addr_q.size() !== 4) begin errors++; $display("FAIL m0_nwrites: got %0d expected 4", wr_addr_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < wr_addr_q.size()) begin
        checks++;
        if (wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== 32'hA0 + 32'(i)) begin
          errors++; $display("FAIL m0_write%0d: got %h@%h expected %h@%h", i, wr_data_q[i], wr_addr_q[i], 32'hA0 + 32'(i), exp_a[i]);
        end
      end
    end
    checks++; if ({done, busy} !== 2'b10) begin errors++; $display("FAIL m0_done: got done,busy=%b expected 10", {done, busy}); end
    checks++; if (count !== 16'd4) begin errors++; $display("FAIL m0_count: got %0d expected 4", count); end
  endtask

  task automatic test_orbit_sync;
    wr_addr_q.delete(); wr_data_q.delete();
    arm(2'd1, 16'd3);
    for (int d = 1; d <= 12; d++) begin
      orbit = (d == 7 || d == 8);
      if (d == 5) begin
        checks++; if ({busy, done} !== 2'b10 || wr_addr_q.size() !== 0) begin
          errors++; $display("FAIL m1_wait: got busy,done=%b writes=%0d expected 10 writes=0", {busy, done}, wr_addr_q.size());
        end
      end
      beat(32'(d));
    end
    tvalid = 1'b0; orbit = 1'b0;
    cyc(3);
    checks++; if (wr_addr_q.size() !== 3) begin errors++; $display("FAIL m1_nwrites: got %0d expected 3", wr_addr_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < wr_addr_q.size()) begin
        checks++;
        if (wr_addr_q[i] !== 32'(4 * i) || wr_data_q[i] !== 32'(7 + i)) begin
          errors++; $display("FAIL m1_write%0d: got %h@%h expected %h@%h", i, wr_data_q[i], wr_addr_q[i], 32'(7 + i), 32'(4 * i));
        end
      end
    end
    checks++; if ({done, count} !== {1'b1, 16'd3}) begin errors++; $display("FAIL m1_done_count: got %b/%0d expected 1/3", done, count); end
  endtask

  task automatic test_ring;
    logic [31:0] exp_m [4] = '{32'h14, 32'h15, 32'h12, 32'h13};
    wr_addr_q.delete(); wr_data_q.delete();
    arm(2'd2, 16'd4);
    for (int i = 0; i < 6; i++) beat(32'h10 + 32'(i));
    tvalid = 1'b0;
    cyc(1);
    checks++; if ({busy, wrapped, done} !== 3'b110) begin errors++; $display("FAIL ring_running: got busy,wrapped,done=%b expected 110", {busy, wrapped, done}); end
    cfg_abort = 1'b1;
    cyc(1);
    cfg_abort = 1'b0;
    cyc(2);
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem[i] !== exp_m[i]) begin errors++; $display("FAIL ring_mem%0d: got %h expected %h", i, mem[i], exp_m[i]); end
    end
    checks++; if ({done, wrapped, busy} !== 3'b110) begin errors++; $display("FAIL ring_final: got done,wrapped,busy=%b expected 110", {done, wrapped, busy}); end
    checks++; if (count !== 16'd6) begin errors++; $display("FAIL ring_count: got %0d expected 6", count); end
  endtask

  task automatic test_full_length;
    wr_addr_q.delete(); wr_data_q.delete();
    arm(2'd0, 16'd0);
    for (int i = 0; i < 2051; i++) beat(32'(i));
    tvalid = 1'b0;
    cyc(3);
    checks++; if (wr_addr_q.size() !== 2048) begin errors++; $display("FAIL full_nwrites: got %0d expected 2048", wr_addr_q.size()); end
    if (wr_addr_q.size() > 0) begin
      checks++;
      if (wr_addr_q[$] !== 32'h1FFC || wr_data_q[$] !== 32'd2047) begin
        errors++; $display("FAIL full_last: got %h@%h expected %h@%h", wr_data_q[$], wr_addr_q[$], 32'd2047, 32'h1FFC);
      end
    end
    checks++; if ({done, count} !== {1'b1, 16'd2048}) begin errors++; $display("FAIL full_done_count: got %b/%0d expected 1/2048", done, count); end
  endtask

  task automatic test_arm_abort;
    arm(2'd0, 16'd8);
    cyc(1);
    cfg_abort = 1'b1;
    cyc(1);
    cfg_abort = 1'b0;
    cyc(1);
    checks++; if ({busy, done, count} !== {2'b00, 16'd0}) begin errors++; $display("FAIL abort_to_idle: got busy,done=%b count=%0d expected 00 0", {busy, done}, count); end
    wr_addr_q.delete(); wr_data_q.delete();
    cfg_arm = 1'b1; cfg_abort = 1'b1; tdata = 32'hDEAD; tvalid = 1'b1;
    cyc(1);
    cfg_arm = 1'b0; cfg_abort = 1'b0;
    cyc(2);
    tvalid = 1'b0;
    checks++; if ({busy, done} !== 2'b00 || wr_addr_q.size() !== 0) begin
      errors++; $display("FAIL arm_abort_same: got busy,done=%b writes=%0d expected 00 0", {busy, done}, wr_addr_q.size());
    end
    arm(2'd0, 16'd8);
    beat(32'h30);
    cfg_arm = 1'b1; cfg_mode = 2'd2; cfg_length = 16'd2;
    beat(32'h31);
    cfg_arm = 1'b0;
    cfg_abort = 1'b1;
    beat(32'h32);
    cfg_abort = 1'b0; tvalid = 1'b0;
    cyc(2);
    checks++; if (count !== 16'd3) begin errors++; $display("FAIL abort_word2_count: got %0d expected 3", count); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_word2_state: got busy,done=%b expected 00", {busy, done}); end
    checks++; if (wr_addr_q.size() !== 3) begin errors++; $display("FAIL abort_word2_nwrites: got %0d expected 3", wr_addr_q.size()); end
    if (wr_addr_q.size() > 0) begin
      checks++;
      if (wr_addr_q[$] !== 32'h8 || wr_data_q[$] !== 32'h32) begin
        errors++; $display("FAIL abort_word2_last: got %h@%h expected 32@8", wr_data_q[$], wr_addr_q[$]);
      end
    end
  endtask

  task automatic test_reset_mid;
    wr_addr_q.delete(); wr_data_q.delete();
    arm(2'd0, 16'd8);
    beat(32'h40); beat(32'h41); beat(32'h42);
    tdata = 32'h43;
    #2 aresetn = 1'b0;
    cyc(1);
    checks++; if ({tready, busy, done, wrapped, bram_WE} !== 8'h00) begin
      errors++; $display("FAIL midrst_flags: got tready,busy,done,wrapped,we=%b expected 0", {tready, busy, done, wrapped, bram_WE});
    end
    checks++; if ({count, bram_ADDR, bram_DIN} !== 80'd0) begin
      errors++; $display("FAIL midrst_regs: got count=%0d addr=%h din=%h expected 0", count, bram_ADDR, bram_DIN);
    end
    cyc(1);
    aresetn = 1'b1;
    cyc(2);
    checks++; if (reset_writes !== 0 || wr_addr_q.size() !== 3) begin
      errors++; $display("FAIL midrst_writes: got reset_writes=%0d total=%0d expected 0 3", reset_writes, wr_addr_q.size());
    end
    arm(2'd0, 16'd2);
    beat(32'h50); beat(32'h51);
    tvalid = 1'b0;
    cyc(2);
    checks++; if (wr_addr_q.size() !== 5) begin errors++; $display("FAIL rearm_nwrites: got %0d expected 5", wr_addr_q.size()); end
    if (wr_addr_q.size() >= 5) begin
      checks++;
      if (wr_addr_q[3] !== 32'h0 || wr_data_q[3] !== 32'h50 || wr_addr_q[4] !== 32'h4 || wr_data_q[4] !== 32'h51) begin
        errors++; $display("FAIL rearm_writes: got %h@%h %h@%h expected 50@0 51@4", wr_data_q[3], wr_addr_q[3], wr_data_q[4], wr_addr_q[4]);
      end
    end
    checks++; if ({done, count} !== {1'b1, 16'd2}) begin errors++; $display("FAIL rearm_done_count: got %b/%0d expected 1/2", done, count); end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_orbit_sync();
    test_ring();
    test_full_length();
    test_arm_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
